// File: rtl/muller_c_arbiter.sv
// muller_c_arbiter: round-robin owner of one shared Muller C-element.
// Each granted requester gets a full rise / hysteresis-hold / fall exercise
// of the element, followed by a one-cycle ack pulse.
// Optional watchdog on RISE/FALL: define C_ARB_TIMEOUT_EN.
module muller_c_arbiter #(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] grant_o,
  output logic [NREQ-1:0] ack_o,
  output logic            busy_o,
  output logic            c_a_o,
  output logic            c_b_o,
  input  logic            c_y_i,
  output logic            mis_o,
  output logic            err_o
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  if (NREQ < 2 || NREQ > 8 || SYNC_STAGES < 2 || HOLD_CYC < 1 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("muller_c_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, RISE, HOLD, FALL, DONE} state_t;

  state_t                 state, state_nxt;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          pick_idx;
  logic                   pick_vld;
  logic [PW:0]            srch;
  logic [SYNC_STAGES-1:0] sync;
  logic                   y_s;
  logic [HW-1:0]          hold_cnt;
  logic                   hold_last;
`ifdef C_ARB_TIMEOUT_EN
  logic [7:0]             wd_cnt;
  logic                   wd_last;
  logic                   wd_fire;
`endif

  assign y_s       = sync[SYNC_STAGES-1];
  assign hold_last = (hold_cnt == HW'(HOLD_CYC - 1));

  // Round-robin search: first set request at or above ptr, wrapping at NREQ
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    srch     = '0;
    for (int k = 0; k < NREQ; k++) begin
      srch = {1'b0, ptr} + (PW+1)'(k);
      if (srch >= (PW+1)'(NREQ)) srch = srch - (PW+1)'(NREQ);
      if (!pick_vld && req_i[srch[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = srch[PW-1:0];
      end
    end
  end

  // Next-state logic for the 4-phase exercise
  always_comb begin
    state_nxt = state;
`ifdef C_ARB_TIMEOUT_EN
    wd_fire   = 1'b0;
`endif
    unique case (state)
      IDLE: if (pick_vld) state_nxt = RISE;
      RISE: begin
        if (y_s) state_nxt = HOLD;
`ifdef C_ARB_TIMEOUT_EN
        else if (wd_last) begin
          state_nxt = IDLE;
          wd_fire   = 1'b1;
        end
`endif
      end
      HOLD: if (hold_last) state_nxt = FALL;
      FALL: begin
        if (!y_s) state_nxt = DONE;
`ifdef C_ARB_TIMEOUT_EN
        else if (wd_last) begin
          state_nxt = IDLE;
          wd_fire   = 1'b1;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner, pointer, synchronizer, hold counter and hysteresis flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_o  <= '0;
      sync     <= '0;
      hold_cnt <= '0;
      mis_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sync     <= {sync[SYNC_STAGES-2:0], c_y_i};
      hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
      if (state == HOLD && !y_s) mis_o <= 1'b1;
      if (state == IDLE && pick_vld) begin
        grant_o <= ONE << pick_idx;
        ptr     <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
      end else if (state != IDLE && state_nxt == IDLE) begin
        grant_o <= '0;
      end
    end
  end

`ifdef C_ARB_TIMEOUT_EN
  assign wd_last = (wd_cnt == 8'(TIMEOUT - 1));

  // Watchdog: restarts on entry to RISE/FALL, counts cycles spent there
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt <= '0;
      err_o  <= 1'b0;
    end else begin
      if (wd_fire) err_o <= 1'b1;
      if ((state_nxt == RISE || state_nxt == FALL) && state_nxt != state)
        wd_cnt <= '0;
      else if (state == RISE || state == FALL)
        wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  assign c_a_o  = (state == RISE);
  assign c_b_o  = (state == RISE) || (state == HOLD);
  assign busy_o = (state != IDLE);
  assign ack_o  = (state == DONE) ? grant_o : '0;

endmodule

// File: tb/tb_muller_c_arbiter.sv
// tb_muller_c_arbiter: randomized, model-checked bench for muller_c_arbiter.
// HOLD_CYC is 3 so that a hysteresis fault, seen through the 2-flop
// synchronizer, lands inside the HOLD window.
module tb_muller_c_arbiter;
  localparam int NREQ = 4;
  localparam int SYNC = 2;
  localparam int HOLD = 3;
  localparam int TMO  = 255;
  localparam int LAT  = 2*SYNC + HOLD + 3;  // edge carrying ack, edge 1 = IDLE sample
  localparam int LAT_HYST = 2*SYNC + HOLD + 1;  // FALL finds y_s already low

  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] grant, ack;
  logic busy, c_a, c_b, mis, err;
  logic c_y = 1'b0;
  int   mode = 0;  // 0 ideal C-element, 1 drops when A falls, 2 stuck at 0
  int   n_cmp = 0, n_bad = 0, cyc = 0, ptr_m = 0;

  muller_c_arbiter #(.NREQ(NREQ), .SYNC_STAGES(SYNC), .HOLD_CYC(HOLD), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req), .grant_o(grant), .ack_o(ack),
    .busy_o(busy), .c_a_o(c_a), .c_b_o(c_b), .c_y_i(c_y), .mis_o(mis), .err_o(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Zero-delay C-element model (with fault modes)
  always @(c_a or c_b or mode) begin
    case (mode)
      0: if (c_a && c_b) c_y = 1'b1; else if (!c_a && !c_b) c_y = 1'b0;
      1: if (c_a && c_b) c_y = 1'b1; else if (!c_a) c_y = 1'b0;
      default: c_y = 1'b0;
    endcase
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "bench timeout");
  end

  // Reference round-robin choice: first requester at or after p, with wrap
  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++)
      if (((r >> ((p + k) % NREQ)) & NREQ'(1)) != '0) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(int w);
    logic [NREQ-1:0] v;
    v = '0;
    if (w >= 0) v = NREQ'(1) << w;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; mode = 0;
    @(posedge clk); #1;
    rst = 1'b0; ptr_m = 0;
  endtask

  // Drives one transaction and reports what it observed (no judging here)
  task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] mid,
                        output logic [NREQ-1:0] g1, output logic cab1, output int lat,
                        output logic [NREQ-1:0] ackv, output int ack_cyc,
                        output logic ack_one, output logic idle_after);
    req = r;
    @(posedge clk); #1;
    g1 = grant; cab1 = c_a & c_b;
    req = mid;
    lat = -1; ackv = '0; ack_cyc = -1;
    for (int n = 2; n <= LAT + 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (ack != '0) begin lat = n; ackv = ack; ack_cyc = cyc; end
    end
    @(posedge clk); #1;
    ack_one    = (ack == '0);
    idle_after = !busy && grant == '0 && !c_a && !c_b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({grant, ack, busy, c_a, c_b, mis, err} !== '0) begin n_bad++;
      $display("FAIL reset_outputs: got %b want all 0", {grant, ack, busy, c_a, c_b, mis, err}); end
    req = '0; rst = 1'b0; ptr_m = 0;
    @(posedge clk); #1;
    n_cmp++; if ({grant, busy} !== '0) begin n_bad++;
      $display("FAIL idle_no_req: got grant %b busy %b want 0", grant, busy); end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g1, av; logic cab, one, idl; int lat, ac;
    do_txn(4'b0010, 4'b0010, g1, cab, lat, av, ac, one, idl);
    req = '0;
    n_cmp++; if (g1 !== 4'b0010) begin n_bad++; $display("FAIL single_grant: got %b want 0010", g1); end
    n_cmp++; if (cab !== 1'b1) begin n_bad++; $display("FAIL single_cab: got %b want 1", cab); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL single_lat: got %0d want %0d", lat, LAT); end
    n_cmp++; if (av !== 4'b0010) begin n_bad++; $display("FAIL single_ack: got %b want 0010", av); end
    n_cmp++; if (one !== 1'b1) begin n_bad++; $display("FAIL single_ack_width: got ack >1 cycle want 1"); end
    n_cmp++; if (mis !== 1'b0) begin n_bad++; $display("FAIL single_mis: got %b want 0", mis); end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] g1, av; logic cab, one, idl; int lat, ac, prev, w;
    int cnt[NREQ];
    do_reset();
    foreach (cnt[i]) cnt[i] = 0;
    prev = -1;
    for (int t = 0; t < 5; t++) begin
      w = rr_pick(4'b1111, ptr_m);
      ptr_m = (w + 1) % NREQ;
      do_txn(4'b1111, 4'b1111, g1, cab, lat, av, ac, one, idl);
      n_cmp++; if (g1 !== oh(w)) begin n_bad++; $display("FAIL fair_grant[%0d]: got %b want %b", t, g1, oh(w)); end
      n_cmp++; if (av !== oh(w)) begin n_bad++; $display("FAIL fair_ack[%0d]: got %b want %b", t, av, oh(w)); end
      if (prev >= 0) begin
        n_cmp++; if (ac - prev !== LAT + 1) begin n_bad++;
          $display("FAIL fair_spacing[%0d]: got %0d want %0d", t, ac - prev, LAT + 1); end
      end
      prev = ac;
      for (int i = 0; i < NREQ; i++) if (g1[i]) cnt[i]++;
      if (t == NREQ - 1) begin
        n_cmp++; if (cnt[0] != 1 || cnt[1] != 1 || cnt[2] != 1 || cnt[3] != 1) begin n_bad++;
          $display("FAIL fair_once: got %0d%0d%0d%0d want 1111", cnt[0], cnt[1], cnt[2], cnt[3]); end
      end
      // the held request is sampled on the very next edge; keep it held
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r, mid, g1, av, e; logic cab, one, idl; int lat, ac, w;
    do_reset();
    for (int t = 0; t < 12; t++) begin
      r   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      mid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      w = rr_pick(r, ptr_m); e = oh(w);
      ptr_m = (w + 1) % NREQ;
      do_txn(r, mid, g1, cab, lat, av, ac, one, idl);
      n_cmp++; if (g1 !== e) begin n_bad++; $display("FAIL rand_grant[%0d]: req %b got %b want %b", t, r, g1, e); end
      n_cmp++; if ({cab, lat} !== {1'b1, LAT}) begin n_bad++;
        $display("FAIL rand_phase[%0d]: got cab %b lat %0d want 1 %0d", t, cab, lat, LAT); end
      n_cmp++; if ({av, one, idl} !== {e, 2'b11}) begin n_bad++;
        $display("FAIL rand_ack[%0d]: got %b/%b/%b want %b/1/1", t, av, one, idl, e); end
    end
    req = '0;
  endtask

  task automatic test_hysteresis();
    logic [NREQ-1:0] g1, av; logic cab, one, idl; int lat, ac;
    do_reset();
    mode = 1;
    n_cmp++; if (mis !== 1'b0) begin n_bad++; $display("FAIL hyst_pre: got %b want 0", mis); end
    do_txn(4'b0001, 4'b0000, g1, cab, lat, av, ac, one, idl);
    n_cmp++; if (av !== 4'b0001) begin n_bad++; $display("FAIL hyst_ack: got %b want 0001", av); end
    n_cmp++; if (lat !== LAT_HYST) begin n_bad++; $display("FAIL hyst_lat: got %0d want %0d", lat, LAT_HYST); end
    n_cmp++; if (mis !== 1'b1) begin n_bad++; $display("FAIL hyst_mis: got %b want 1", mis); end
    mode = 0;
    do_txn(4'b0100, 4'b0000, g1, cab, lat, av, ac, one, idl);
    n_cmp++; if ({av, mis} !== {4'b0100, 1'b1}) begin n_bad++;
      $display("FAIL hyst_sticky: got ack %b mis %b want 0100 1", av, mis); end
    do_reset();
    n_cmp++; if (mis !== 1'b0) begin n_bad++; $display("FAIL hyst_clear: got %b want 0", mis); end
  endtask

  task automatic test_reset_mid_hold();
    logic [NREQ-1:0] bad_ack, got; int seen;
    do_reset();
    req = 4'b0100;
    @(posedge clk); #1;
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL rmh_grant: got %b want 0100", grant); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({c_a, c_b} !== 2'b01) begin n_bad++; $display("FAIL rmh_hold: got %b want 01", {c_a, c_b}); end
    rst = 1'b1; req = 4'b1111;
    @(posedge clk); #1;
    n_cmp++; if ({grant, ack, busy, c_a, c_b} !== '0) begin n_bad++;
      $display("FAIL rmh_outputs: got %b want all 0", {grant, ack, busy, c_a, c_b}); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rmh_regrant: got %b want 0001", grant); end
    req = '0; bad_ack = '0; got = '0; seen = 0;
    for (int n = 0; n < LAT + 20 && seen == 0; n++) begin
      @(posedge clk); #1;
      if (ack != '0) begin got = ack; seen = 1; end
      if ((ack & 4'b0100) != '0) bad_ack = ack;
    end
    n_cmp++; if ({got, bad_ack} !== {4'b0001, 4'b0000}) begin n_bad++;
      $display("FAIL rmh_ack: got %b stray %b want 0001 0000", got, bad_ack); end
    @(posedge clk); #1;
  endtask

  task automatic test_early_drop();
    logic [NREQ-1:0] g1, av; logic cab, one, idl; int lat, ac;
    do_reset();
    do_txn(4'b1000, 4'b0000, g1, cab, lat, av, ac, one, idl);
    n_cmp++; if ({g1, av} !== {4'b1000, 4'b1000}) begin n_bad++;
      $display("FAIL drop_ack: got grant %b ack %b want 1000 1000", g1, av); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL drop_lat: got %0d want %0d", lat, LAT); end
    n_cmp++; if (idl !== 1'b1) begin n_bad++; $display("FAIL drop_idle: got %b want 1", idl); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_stay_idle: got %b want 0", busy); end
  endtask

  task automatic test_stuck();
    logic any_ack, early;
    do_reset();
    mode = 2; req = 4'b0011;
    @(posedge clk); #1;
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL stuck_grant: got %b want 0001", grant); end
`ifdef C_ARB_TIMEOUT_EN
    any_ack = 1'b0; early = 1'b0;
    for (int n = 2; n <= TMO; n++) begin
      @(posedge clk); #1;
      if (ack != '0) any_ack = 1'b1;
      if (err || !c_a) early = 1'b1;
    end
    n_cmp++; if ({any_ack, early} !== 2'b00) begin n_bad++;
      $display("FAIL stuck_wait: got ack %b early %b want 0 0", any_ack, early); end
    @(posedge clk); #1;
    n_cmp++; if ({err, c_a, c_b, busy, ack, grant} !== {1'b1, 3'b000, 8'h00}) begin n_bad++;
      $display("FAIL stuck_timeout: got err %b c %b%b busy %b ack %b grant %b want 1 00 0 0000 0000",
               err, c_a, c_b, busy, ack, grant); end
    mode = 0;
    @(posedge clk); #1;
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL stuck_next: got %b want 0010", grant); end
    req = '0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    n_cmp++; if ({err, busy} !== 2'b10) begin n_bad++;
      $display("FAIL stuck_after: got err %b busy %b want 1 0", err, busy); end
`else
    any_ack = 1'b0; early = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (ack != '0) any_ack = 1'b1;
      if (err || !busy || !c_a) early = 1'b1;
    end
    n_cmp++; if ({any_ack, early} !== 2'b00) begin n_bad++;
      $display("FAIL stuck_wait: got ack %b left_rise %b want 0 0", any_ack, early); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_random();
    test_hysteresis();
    test_reset_mid_hold();
    test_early_drop();
    test_stuck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
